// File: rtl/ex_pkg.sv
// ex_pkg: ALU opcodes, datapath defaults and multiplier FSM states for the execute stage.
package ex_pkg;
    localparam int XLEN_DEF       = 32;
    localparam int MUL_CYCLES_DEF = 32;

    localparam logic [3:0] ALU_PASSA = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_NEG   = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_OR    = 4'd5;
    localparam logic [3:0] ALU_XOR   = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mulState_e;
endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: shift-add multiplier, one partial product per cycle, IDLE/BUSY/DONE control.
// The module only exists when EX_MUL_EN is defined.
`ifdef EX_MUL_EN
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output mulState_e       state,
    output logic [XLEN-1:0] product
);
    mulState_e       stateNext;
    logic [4:0]      count;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic            lastStep;

    assign lastStep = count == 5'(MUL_CYCLES - 1);
    assign product  = acc;

    always_comb begin
        stateNext = abort ? MUL_IDLE
                  : state == MUL_IDLE ? (start ? MUL_BUSY : MUL_IDLE)
                  : state == MUL_BUSY ? (lastStep ? MUL_DONE : MUL_BUSY)
                  : MUL_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MUL_IDLE;
        else        state <= stateNext;
    end

    // Multiplicand walks left and multiplier walks right; low bit of the multiplier gates each add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (state == MUL_IDLE && start) begin
            count  <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (state == MUL_BUSY) begin
            count  <= count + 5'd1;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc + (mplier[0] ? mcand : '0);
        end
    end
endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage: execute stage - ALU, branch/jump resolution on registered N/Z flags, EX/MEM register.
// Define EX_MUL_EN to build the iterative multiplier; otherwise aluOp MUL yields 0 with no stall.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
`ifdef EX_MUL_EN
    ,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            branchN_i,
    input  logic            branchZ_i,
    input  logic            jump_i,
    input  logic            jumpMem_i,
    input  logic            memRead_i,
    input  logic            memToReg_i,
    input  logic            memWrite_i,
    input  logic            aluSrc_i,
    input  logic            regWrt_i,
    input  logic            svpc_i,
    input  logic [3:0]      aluOp_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            valid_o,
    output logic            memRead_o,
    output logic            memToReg_o,
    output logic            memWrite_o,
    output logic            regWrt_o,
    output logic            jumpMem_o,
    output logic [XLEN-1:0] result_o,
    output logic [XLEN-1:0] storeData_o,
    output logic [4:0]      rd_o
);
    logic [XLEN-1:0] opB;
    logic [XLEN-1:0] aluRes;
    logic [XLEN-1:0] mulResult;
    logic [XLEN-1:0] result;
    logic            isMul;
    logic            mulDone;
    logic            taken;
    logic            capture;
    logic            redirNext;
    logic            flagN;
    logic            flagZ;

    assign opB   = aluSrc_i ? imm_i : rs2_i;
    // svpc takes the PC-relative path, so it never starts the multiplier.
    assign isMul = aluOp_i == ALU_MUL && !svpc_i;

    always_comb begin
        aluRes = '0;
        case (aluOp_i)
            ALU_PASSA: aluRes = rs1_i;
            ALU_ADD:   aluRes = rs1_i + opB;
            ALU_SUB:   aluRes = rs1_i - opB;
            ALU_NEG:   aluRes = '0 - rs1_i;
            ALU_AND:   aluRes = rs1_i & opB;
            ALU_OR:    aluRes = rs1_i | opB;
            ALU_XOR:   aluRes = rs1_i ^ opB;
            ALU_SLL:   aluRes = rs1_i << opB[4:0];
            ALU_SRL:   aluRes = rs1_i >> opB[4:0];
            ALU_SRA:   aluRes = $unsigned($signed(rs1_i) >>> opB[4:0]);
            default:   aluRes = '0;
        endcase
    end

`ifdef EX_MUL_EN
    mulState_e mulState;
    logic      mulStart;

    assign mulStart = valid_i && isMul && !flush_i;

    ex_mul_iter #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) uMul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mulStart),
        .abort   (flush_i),
        .a       (rs1_i),
        .b       (opB),
        .state   (mulState),
        .product (mulResult)
    );

    assign stall_o = (mulState == MUL_IDLE && mulStart) || mulState == MUL_BUSY;
    assign mulDone = mulState == MUL_DONE;
`else
    assign stall_o   = 1'b0;
    assign mulDone   = 1'b0;
    assign mulResult = '0;
`endif

    assign result    = svpc_i ? pc_i + imm_i : mulDone ? mulResult : aluRes;
    assign taken     = (branchZ_i && flagZ) || (branchN_i && flagN);
    assign capture   = valid_i && !stall_o && !flush_i;
    assign redirNext = capture && !isMul && (jump_i || taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o       <= 1'b0;
            memRead_o     <= 1'b0;
            memToReg_o    <= 1'b0;
            memWrite_o    <= 1'b0;
            regWrt_o      <= 1'b0;
            jumpMem_o     <= 1'b0;
            result_o      <= '0;
            storeData_o   <= '0;
            rd_o          <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            flagN         <= 1'b0;
            flagZ         <= 1'b0;
        end else begin
            valid_o     <= capture;
            memRead_o   <= capture && memRead_i;
            memToReg_o  <= capture && memToReg_i;
            memWrite_o  <= capture && memWrite_i;
            regWrt_o    <= capture && regWrt_i;
            jumpMem_o   <= capture && jumpMem_i;
            result_o    <= result;
            storeData_o <= rs2_i;
            rd_o        <= rd_i;
            redirect_o  <= redirNext;
            if (redirNext) redirect_pc_o <= rs1_i;
            if (capture && regWrt_i) begin
                flagN <= result[XLEN-1];
                flagZ <= result == '0;
            end
        end
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register.
- Consumes the registered control, operands, immediate, rd and PC from ID/EX.
- Performs the ALU operation and resolves branches and jumps against registered N/Z flags.
- Captures results into an internal EX/MEM register; an iterative multiplier stalls the front end while it runs.

Parameters:
- XLEN, 32, datapath width.
- MUL_CYCLES, 32, multiplier iteration count; one partial-product step per cycle.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  ID/EX holds a real instruction (0 = bubble)
- branchN_i, branchZ_i, jump_i, jumpMem_i, memRead_i, memToReg_i, memWrite_i, aluSrc_i, regWrt_i, svpc_i  in  1 each  decoded control from ID/EX
- aluOp_i  in  4  ALU opcode
- imm_i, rs1_i, rs2_i, pc_i  in  XLEN each  immediate, source operands, instruction PC
- rd_i  in  5  destination register
- flush_i  in  1  kill from a later stage (jumpMem resolution)
- stall_o  out  1  hold IF/ID and ID/EX this cycle
- redirect_o  out  1  one-cycle PC redirect pulse; also flushes IF/ID and ID/EX
- redirect_pc_o  out  XLEN  redirect target
- valid_o, memRead_o, memToReg_o, memWrite_o, regWrt_o, jumpMem_o  out  1 each  EX/MEM control
- result_o, storeData_o  out  XLEN each  ALU/product result, rs2 passthrough
- rd_o  out  5  destination register

Behaviour:
- Reset: all registered outputs and flags N=Z=0 return to 0; FSM returns to IDLE. stall_o and redirect_o read 0.
- Operand B = aluSrc_i ? imm_i : rs2_i.
- aluOp encoding:
  - 0 PASSA, 1 ADD, 2 SUB (A-B), 3 NEG (-A), 4 AND, 5 OR, 6 XOR
  - 7 SLL, 8 SRL, 9 SRA; shift amount is B[4:0]
  - 10 MUL (low XLEN bits of product)
  - 11..15 produce 0
- Arithmetic wraps modulo 2^XLEN.
- svpc_i=1 overrides the ALU: result = pc_i + imm_i.
- Non-MUL latency: 1 cycle. When valid_i and not stalled, EX/MEM captures at the clock edge and valid_o=1 the next cycle.
- Bubble (valid_i=0): EX/MEM captures valid_o=0 and all write/mem controls 0. Data fields are don't-care.
- Flags: N=result[XLEN-1] and Z=(result==0). Updated only when a valid regWrt_i=1 instruction is captured into EX/MEM.
- Branch resolution uses the flag values held before the instruction's capture. taken = branchZ_i&Z | branchN_i&N.
  - Taken branch: redirect_pc = rs1_i.
  - jump_i=1: redirect_pc = rs1_i, unconditional.
  - redirect_o and redirect_pc_o are registered and pulse for exactly one cycle after capture.
- jumpMem_i is not redirected here; it passes to jumpMem_o for MEM to resolve.
- MUL FSM: IDLE -> BUSY -> DONE -> IDLE.
  - Cycle T, IDLE with valid_i and aluOp==10: latch operands, count=0, go to BUSY. stall_o=1 combinationally.
  - BUSY: one iteration per cycle, stall_o=1, EX/MEM captures a bubble. After count==MUL_CYCLES-1, go to DONE.
  - DONE: stall_o=0. Product is captured into EX/MEM with the instruction's controls; return to IDLE.
  - Default timing: stall_o high T..T+32, product on result_o at T+34.
- flush_i has priority over everything:
  - The next EX/MEM contents are a bubble.
  - Any pending redirect is suppressed.
  - The FSM aborts to IDLE with counter cleared.
  - Flags are unchanged.
- Simultaneous redirect generation and MUL start cannot occur: a MUL never carries branch/jump control. If it does, branch/jump control is ignored.
- rst_n asserted mid-multiply: FSM returns to IDLE immediately; the partial product is discarded.

Optional Feature:
- EX_MUL_EN defined: iterative multiplier and FSM present as above.
- EX_MUL_EN undefined: aluOp 10 yields result 0 in 1 cycle, stall_o is tied 0, and no FSM is instantiated.

Decomposition:
- Package ex_pkg: ALU opcode localparams (ALU_PASSA..ALU_MUL), XLEN default, MUL FSM state encoding.
- One sub-module, ex_mul_iter: shift-add multiplier with start/abort/done and a 5-bit counter.

Test Plan:
- Reset mid-stream: rst_n=0 -> all outputs 0 asynchronously, FSM IDLE, flags N=Z=0.
- ADD rs1=5, rs2=7, regWrt=1 -> result_o=12, valid_o=1 one cycle later, Z=0, N=0.
- SUB 3-3 (sets Z=1), then branchZ with rs1=0x40 -> redirect_o pulses one cycle with redirect_pc_o=0x40. Repeat with Z=0 -> no redirect.
- svpc with pc=0x100, imm=8 -> result_o=0x108 regardless of aluOp.
- MUL 0xFFFF x 0x10001 (EX_MUL_EN) -> stall_o high 33 cycles, then result_o=0xFFFFFFFF with valid_o=1. Without the macro: result_o=0, no stall.
- flush_i during MUL BUSY cycle 10 -> stall_o drops next cycle, valid_o=0, no result written, flags unchanged.
